// File: rtl/mem_responder_pkg.sv
// Shared bus encodings, tag constants and pipeline entry type for the memory-side responder.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_t;

    localparam int unsigned MEM_TAG_BITS = 4;
    localparam int unsigned MEM_NUM_TAGS = 15;

    typedef struct packed {
        logic                    valid;
        logic [MEM_TAG_BITS-1:0] tag;
        logic [63:0]             data;
    } pipe_entry_t;

endpackage

// File: rtl/mem_tag_alloc.sv
// Free-tag bookkeeping: tags 1..15, lowest free tag offered; tag 0 is never handed out.
module mem_tag_alloc
    import mem_responder_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    alloc_en,
    input  logic                    free_en,
    input  logic [MEM_TAG_BITS-1:0] free_tag,
    output logic                    free_tag_valid,
    output logic [MEM_TAG_BITS-1:0] alloc_tag
);

    logic [MEM_NUM_TAGS:1] free_mask_q;

    // Falls back to the top tag when nothing is free, which is what stores report.
    always_comb begin
        free_tag_valid = |free_mask_q;
        alloc_tag      = MEM_TAG_BITS'(MEM_NUM_TAGS);
        for (int i = MEM_NUM_TAGS; i >= 1; i--) begin
            if (free_mask_q[i]) begin
                alloc_tag = MEM_TAG_BITS'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            free_mask_q <= '1;
        end else begin
            if (free_en) begin
                free_mask_q[free_tag] <= 1'b1;
            end
            if (alloc_en && free_tag_valid) begin
                free_mask_q[alloc_tag] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: tagged load/store acceptance, fixed-latency load return,
// and periodic refresh windows that reject commands.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned MEM_LINES      = 1024,
    parameter int unsigned LATENCY        = 4,
    parameter int unsigned REFRESH_PERIOD = 32,
    parameter int unsigned REFRESH_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              proc2mem_command,
    input  logic [63:0]             proc2mem_addr,
    input  logic [63:0]             proc2mem_data,
    output logic [MEM_TAG_BITS-1:0] mem2proc_response,
    output logic [63:0]             mem2proc_data,
    output logic [MEM_TAG_BITS-1:0] mem2proc_tag
);

    localparam int unsigned IDX_BITS   = $clog2(MEM_LINES);
    localparam logic [63:0] ADDR_LIMIT = 64'(MEM_LINES) * 64'd8;

    logic [63:0]             mem_array [MEM_LINES];
    pipe_entry_t             pipe_q [LATENCY];
    logic [31:0]             rc_q;
    logic [IDX_BITS-1:0]     index;
    logic [63:0]             read_data;
    logic                    in_refresh;
    logic                    addr_ok;
    logic                    can_accept;
    logic                    load_accept;
    logic                    store_accept;
    logic                    free_tag_valid;
    logic [MEM_TAG_BITS-1:0] alloc_tag;
    pipe_entry_t             exit_entry;

    assign index      = proc2mem_addr[3 +: IDX_BITS];
    assign read_data  = mem_array[index];
    assign exit_entry = pipe_q[LATENCY-1];

    always_comb begin
        in_refresh   = (REFRESH_CYCLES != 0) && (rc_q >= 32'(REFRESH_PERIOD - REFRESH_CYCLES));
        addr_ok      = (proc2mem_addr[2:0] == 3'b000) && (proc2mem_addr < ADDR_LIMIT);
        can_accept   = !reset && addr_ok && !in_refresh;
        load_accept  = can_accept && (proc2mem_command == BUS_LOAD) && free_tag_valid;
        store_accept = can_accept && (proc2mem_command == BUS_STORE);
        mem2proc_response = (load_accept || store_accept) ? alloc_tag : '0;
        mem2proc_tag      = exit_entry.valid ? exit_entry.tag : '0;
        mem2proc_data     = exit_entry.valid ? exit_entry.data : '0;
    end

    mem_tag_alloc u_tag_alloc (
        .clock          (clock),
        .reset          (reset),
        .alloc_en       (load_accept),
        .free_en        (exit_entry.valid),
        .free_tag       (exit_entry.tag),
        .free_tag_valid (free_tag_valid),
        .alloc_tag      (alloc_tag)
    );

    // Pipeline keeps moving through refresh; reset drops everything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= '{valid: load_accept, tag: alloc_tag, data: read_data};
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (store_accept) begin
            mem_array[index] <= proc2mem_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rc_q <= '0;
        end else if (rc_q == REFRESH_PERIOD - 1) begin
            rc_q <= '0;
        end else begin
            rc_q <= rc_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder: default build plus a long-latency,
// no-refresh build driven by the same stimulus.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int unsigned ML = 1024;
    localparam int unsigned RP = 32;

    typedef struct {
        longint      due;
        logic [3:0]  tag;
        logic [63:0] data;
        bit          known;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cmd   = 2'b00;
    logic [63:0] addr  = '0;
    logic [63:0] wdata = '0;
    logic [3:0]  resp_a, tag_a, resp_b, tag_b;
    logic [63:0] data_a, data_b;

    int     checks   = 0;
    int     failures = 0;
    bit     started  = 0;
    longint abs_cyc  = 0;
    longint rcyc     = 0;

    longint      busy_until [2][16];
    logic [63:0] mem_m      [2][ML];
    bit          known_m    [2][ML];
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        abs_cyc <= abs_cyc + 1;
        rcyc    <= reset ? 0 : rcyc + 1;
    end

    mem_responder dut_a (
        .clock             (clock),
        .reset             (reset),
        .proc2mem_command  (cmd),
        .proc2mem_addr     (addr),
        .proc2mem_data     (wdata),
        .mem2proc_response (resp_a),
        .mem2proc_data     (data_a),
        .mem2proc_tag      (tag_a)
    );

    mem_responder #(
        .LATENCY        (16),
        .REFRESH_CYCLES (0)
    ) dut_b (
        .clock             (clock),
        .reset             (reset),
        .proc2mem_command  (cmd),
        .proc2mem_addr     (addr),
        .proc2mem_data     (wdata),
        .mem2proc_response (resp_b),
        .mem2proc_data     (data_b),
        .mem2proc_tag      (tag_b)
    );

    function automatic longint lat_of(input int inst);
        return (inst == 0) ? 64'd4 : 64'd16;
    endfunction

    function automatic longint rcy_of(input int inst);
        return (inst == 0) ? 64'd4 : 64'd0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, abs_cyc, act, exp);
        end
    endtask

    // Reference model for one cycle of one instance, evaluated from the bus rules.
    task automatic model_cycle(input int inst, input logic [3:0] resp);
        logic [3:0] exp_resp;
        int         tag_found;
        bit         ok;
        bit         blocked;
        int         idx;
        exp_t       e;
        exp_resp  = 4'd0;
        tag_found = 0;
        if (reset) begin
            for (int t = 1; t <= 15; t++) busy_until[inst][t] = abs_cyc;
            if (inst == 0) begin
                while (q0.size() > 0 && q0[$].due > abs_cyc) void'(q0.pop_back());
            end else begin
                while (q1.size() > 0 && q1[$].due > abs_cyc) void'(q1.pop_back());
            end
        end else begin
            blocked = (rcy_of(inst) != 0) && ((rcyc % RP) >= (RP - rcy_of(inst)));
            ok = (cmd != BUS_NONE) && (addr % 8 == 0) && (addr < 64'(ML) * 8) && !blocked;
            for (int t = 15; t >= 1; t--) begin
                if (busy_until[inst][t] < abs_cyc) tag_found = t;
            end
            idx = int'(addr[12:3]);
            if (ok && cmd == BUS_LOAD && tag_found != 0) begin
                exp_resp = 4'(tag_found);
                busy_until[inst][tag_found] = abs_cyc + lat_of(inst);
                e.due   = abs_cyc + lat_of(inst);
                e.tag   = 4'(tag_found);
                e.data  = mem_m[inst][idx];
                e.known = known_m[inst][idx];
                if (inst == 0) q0.push_back(e);
                else q1.push_back(e);
            end else if (ok && cmd == BUS_STORE) begin
                exp_resp = (tag_found != 0) ? 4'(tag_found) : 4'd15;
                mem_m[inst][idx]   = wdata;
                known_m[inst][idx] = 1'b1;
            end
        end
        check((inst == 0) ? "resp_a" : "resp_b", 64'(resp), 64'(exp_resp));
    endtask

    task automatic step(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d,
                        input logic r);
        @(negedge clock);
        reset = r;
        cmd   = c;
        addr  = a;
        wdata = d;
        #1;
        model_cycle(0, resp_a);
        model_cycle(1, resp_b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(BUS_NONE, 64'd0, 64'd0, 1'b0);
    endtask

    task automatic monitor(input int inst);
        exp_t        e;
        bit          have;
        logic [3:0]  tg;
        logic [63:0] dt;
        forever begin
            @(negedge clock);
            #2;
            tg   = (inst == 0) ? tag_a : tag_b;
            dt   = (inst == 0) ? data_a : data_b;
            have = (inst == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (have) e = (inst == 0) ? q0[0] : q1[0];
            if (have && e.due <= abs_cyc) begin
                check((inst == 0) ? "ret_tag_a" : "ret_tag_b", 64'(tg), 64'(e.tag));
                if (e.known) check((inst == 0) ? "ret_data_a" : "ret_data_b", dt, e.data);
                if (inst == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end else begin
                check((inst == 0) ? "idle_tag_a" : "idle_tag_b", 64'(tg), 64'd0);
            end
        end
    endtask

    initial begin
        wait (started);
        monitor(0);
    end

    initial begin
        wait (started);
        monitor(1);
    end

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r < 16) return 64'(r) * 8;
        if (r == 16) return 64'h44;
        if (r == 17) return 64'(ML) * 8;
        if (r == 18) return 64'(ML) * 8 - 8;
        return 64'hFFFF_FFFF_FFFF_FFF8;
    endfunction

    initial begin
        logic [63:0] rd;
        int          rsel;
        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < 16; t++) busy_until[i][t] = -1;
            for (int w = 0; w < int'(ML); w++) known_m[i][w] = 1'b0;
        end
        repeat (3) step(BUS_NONE, 64'd0, 64'd0, 1'b1);
        started = 1;

        // Store then load back the same word.
        step(BUS_STORE, 64'h40, 64'hDEAD_BEEF, 1'b0);
        step(BUS_LOAD, 64'h40, 64'd0, 1'b0);
        idle(6);
        for (int w = 0; w < 16; w++) step(BUS_STORE, 64'(w) * 8, {$urandom, $urandom}, 1'b0);
        step(BUS_STORE, 64'(ML) * 8 - 8, {$urandom, $urandom}, 1'b0);
        idle(20);

        // Back-to-back loads and address filtering.
        for (int w = 0; w < 4; w++) step(BUS_LOAD, 64'(w) * 8, 64'd0, 1'b0);
        step(BUS_LOAD, 64'h44, 64'd0, 1'b0);
        step(BUS_LOAD, 64'(ML) * 8, 64'd0, 1'b0);
        step(BUS_STORE, 64'(ML) * 8, 64'h1234, 1'b0);
        step(BUS_NONE, 64'h0, 64'd0, 1'b0);
        step(BUS_LOAD, 64'h0, 64'd0, 1'b0);
        idle(20);

        // Tag exhaustion on the long-latency build.
        step(BUS_NONE, 64'd0, 64'd0, 1'b1);
        for (int i = 0; i < 16; i++) step(BUS_LOAD, 64'(i % 16) * 8, 64'd0, 1'b0);
        step(BUS_STORE, 64'h30, 64'hCAFE_F00D_0000_0001, 1'b0);
        step(BUS_LOAD, 64'h10, 64'd0, 1'b0);
        idle(17);
        step(BUS_LOAD, 64'h30, 64'd0, 1'b0);
        idle(20);

        // Refresh windows with a load held every cycle.
        step(BUS_NONE, 64'd0, 64'd0, 1'b1);
        for (int i = 0; i < 70; i++) step(BUS_LOAD, 64'h8, 64'd0, 1'b0);
        idle(20);

        // Reset drops an in-flight load.
        step(BUS_LOAD, 64'h0, 64'd0, 1'b0);
        step(BUS_NONE, 64'd0, 64'd0, 1'b0);
        step(BUS_NONE, 64'd0, 64'd0, 1'b1);
        step(BUS_LOAD, 64'h0, 64'd0, 1'b0);
        idle(20);

        for (int i = 0; i < 2500; i++) begin
            rsel = int'($urandom_range(0, 3));
            rd   = rand_addr();
            if ($urandom_range(0, 149) == 0) begin
                step(BUS_NONE, 64'd0, 64'd0, 1'b1);
            end else if (rsel < 2) begin
                step(BUS_LOAD, rd, 64'd0, 1'b0);
            end else if (rsel == 2) begin
                step(BUS_STORE, rd, {$urandom, $urandom}, 1'b0);
            end else begin
                step(BUS_NONE, rd, 64'd0, 1'b0);
            end
        end
        idle(25);
        check("drain_a", 64'(q0.size()), 64'd0);
        check("drain_b", 64'(q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
